bcd_angle_counter: RTL and testbench
====================================

Name: bcd_angle_counter

Overview:
- Parametrised successor to the 4-digit BCD angle counter driving the 7-segment display path.
- Counts rot_clk falling edges in packed BCD, up or down, with modulo wrap at a configurable limit (default 360 degrees).
- Adds synchronous clear and load, and a wrap pulse.
- Runs entirely in the clk50 domain; rot_clk is synchronised and edge-detected rather than used as a clock.

Parameters:
- DIGITS, 4, number of BCD digits; legal range 1..8.
- MOD_VALUE, 360, count range is 0..MOD_VALUE-1; legal range 2..10^DIGITS (10^DIGITS gives the full 9..9 -> 0 rollover).

Ports:
- clk50  input  1  system clock, all logic on the rising edge
- sys_init_ctrl  input  1  asynchronous active-high reset
- rot_clk  input  1  asynchronous step strobe; each falling edge is one step
- rot_en  input  1  step enable, synchronous to clk50
- rot_dir  input  1  1 = increment, 0 = decrement; synchronous to clk50
- clear  input  1  synchronous clear to zero
- load  input  1  synchronous load strobe
- load_val  input  4*DIGITS  packed BCD load value, digit 0 in bits [3:0]
- bcdint  output  4*DIGITS  packed BCD count, digit 0 in bits [3:0]
- wrap  output  1  one-cycle pulse on modulo wrap
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset: sys_init_ctrl high clears the following immediately, regardless of clk50:
  - bcdint = 0, wrap = 0, load_err = 0.
  - The sync flops s1 and s2 and the edge-history flop s3 all go to 0, so no false falling edge is seen after release.
  - Reset asserted mid-operation discards any in-flight step.
- Synchroniser: s1 <= rot_clk, s2 <= s1, s3 <= s2. step = s3 & ~s2.
- Step latency: a rot_clk fall first sampled at clk50 edge k updates bcdint at edge k+2.
- Step qualification: rot_en and rot_dir are sampled in the cycle step is high. A step with rot_en = 0 is dropped, not queued.
- Priority per cycle is clear > load > step; lower-priority events in the same cycle are discarded.
  - clear: bcdint <= 0; wrap stays 0.
  - load: accepted only if every digit is at most 9 and the value is below MOD_VALUE. Accepted: bcdint <= load_val. Rejected: bcdint unchanged and load_err = 1 for one cycle.
  - up step:
    - If bcdint == MOD_VALUE-1: bcdint <= 0 and wrap = 1.
    - Otherwise BCD increment: digit 0 +1; a digit at 9 becomes 0 and carries into the next digit.
  - down step:
    - If bcdint == 0: bcdint <= MOD_VALUE-1 (BCD) and wrap = 1.
    - Otherwise BCD decrement: digit 0 -1; a digit at 0 becomes 9 and borrows from the next digit.
- Arithmetic: pure per-digit BCD; no binary conversion. MOD_VALUE-1 is converted to a BCD constant at elaboration.
- wrap and load_err are registered and high for exactly one clk50 cycle.
- Boundary rules:
  - Back-to-back rot_clk falls less than 2 clk50 periods apart are not guaranteed to be counted; the system constraint is a rot_clk period of at least 4 clk50 periods.
  - A rot_clk fall that arrives during reset is not counted.

Optional Feature:
- Macro: BCD_ANGLE_SAT_EN.
- Defined: saturating mode.
  - An up step at MOD_VALUE-1 holds the value.
  - A down step at 0 holds 0.
  - wrap is never asserted; it is replaced by the same pulse flagging saturation, with the same timing.
- Undefined: modulo wrap exactly as in Behaviour.

Test Plan:
- Reset with rot_clk held low, then release -> no step; bcdint = 0x0000 for 10 cycles.
- Defaults, rot_en = 1, rot_dir = 1, 361 rot_clk falls -> bcdint runs 0000..0359, then 0000, then 0001; wrap pulses exactly once, on the 0359 -> 0000 step; every edge latency is 2 cycles after first sample.
- rot_dir = 0 from 0000, one fall -> 0359 with wrap = 1. Load 0100, then one down fall -> 0099 (borrow chain).
- Load 0x0360 -> load_err pulse, bcdint unchanged. Load 0x01A0 -> load_err pulse. Load 0x0123 -> bcdint = 0x0123.
- clear, load and step in the same cycle -> bcdint = 0. Load and step together -> load value wins. Assert sys_init_ctrl between two clk50 edges -> bcdint = 0 immediately.
- MOD_VALUE = 10000, start 9998, two up falls -> 9999, then 0000 with wrap. With BCD_ANGLE_SAT_EN defined, the second fall holds 9999 and the pulse fires.

Source files
------------

// File: rtl/bcd_angle_counter_if.sv
// Bus between the angle counter and its controller: step inputs, clear/load
// controls and the packed BCD count with its one-cycle status pulses.
interface bcd_angle_counter_if #(
  parameter int DIGITS = 4
);
  // rot_clk is asynchronous; every other input is a level sampled on the
  // rising clk50 edge with no handshake. wrap/load_err are single-cycle pulses.
  logic                  rot_clk;
  logic                  rot_en;
  logic                  rot_dir;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcdint;
  logic                  wrap;
  logic                  load_err;

  modport master (
    output rot_clk, rot_en, rot_dir, clear, load, load_val,
    input  bcdint, wrap, load_err
  );

  modport slave (
    input  rot_clk, rot_en, rot_dir, clear, load, load_val,
    output bcdint, wrap, load_err
  );
endinterface

// File: rtl/bcd_angle_counter.sv
// Packed-BCD up/down angle counter stepped by rot_clk falling edges, modulo MOD_VALUE.
// Define BCD_ANGLE_SAT_EN to saturate at the range ends instead of wrapping.
module bcd_angle_counter #(
  parameter int DIGITS    = 4,
  parameter int MOD_VALUE = 360
) (
  input  logic               clk50,
  input  logic               sys_init_ctrl,
  bcd_angle_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] res;
    int           rem;
    res = '0;
    rem = value;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(rem % 10);
      rem           = rem / 10;
    end
    return res;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MOD_VALUE - 1);

  logic         s1, s2, s3;
  logic         step;
  logic [W-1:0] count;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         load_ok;
  logic         wrap_q;
  logic         err_q;

  assign step = s3 & ~s2;

  always_comb begin : bcd_inc
    logic carry;
    inc_val = '0;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!carry) begin
        inc_val[4*i +: 4] = count[4*i +: 4];
      end else if (count[4*i +: 4] == 4'd9) begin
        inc_val[4*i +: 4] = 4'd0;
      end else begin
        inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
        carry             = 1'b0;
      end
    end
  end

  always_comb begin : bcd_dec
    logic borrow;
    dec_val = '0;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!borrow) begin
        dec_val[4*i +: 4] = count[4*i +: 4];
      end else if (count[4*i +: 4] == 4'd0) begin
        dec_val[4*i +: 4] = 4'd9;
      end else begin
        dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
        borrow            = 1'b0;
      end
    end
  end

  // With every digit valid, packed-BCD order equals unsigned vector order.
  always_comb begin
    load_ok = (bus.load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  always_ff @(posedge clk50 or posedge sys_init_ctrl) begin
    if (sys_init_ctrl) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      count  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      s1     <= bus.rot_clk;
      s2     <= s1;
      s3     <= s2;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.clear) begin
        count <= '0;
      end else if (bus.load) begin
        if (load_ok) count <= bus.load_val;
        else         err_q <= 1'b1;
      end else if (step && bus.rot_en) begin
        if (bus.rot_dir) begin
          if (count == MAX_BCD) begin
`ifdef BCD_ANGLE_SAT_EN
            count  <= count;
`else
            count  <= '0;
`endif
            wrap_q <= 1'b1;
          end else begin
            count <= inc_val;
          end
        end else begin
          if (count == '0) begin
`ifdef BCD_ANGLE_SAT_EN
            count  <= '0;
`else
            count  <= MAX_BCD;
`endif
            wrap_q <= 1'b1;
          end else begin
            count <= dec_val;
          end
        end
      end
    end
  end

  assign bus.bcdint   = count;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;
endmodule

// File: tb/tb_bcd_angle_counter.sv
// Bench for bcd_angle_counter: a 360-degree and a 10000-range instance share
// stimulus and are checked against an integer model of the counting rules.
module tb_bcd_angle_counter;
  logic clk50 = 1'b0;
  logic sys_init_ctrl = 1'b1;

  bcd_angle_counter_if #(.DIGITS(4)) bus_a ();
  bcd_angle_counter_if #(.DIGITS(4)) bus_b ();

  bcd_angle_counter #(.DIGITS(4), .MOD_VALUE(360)) dut_a (
    .clk50(clk50), .sys_init_ctrl(sys_init_ctrl), .bus(bus_a.slave));
  bcd_angle_counter #(.DIGITS(4), .MOD_VALUE(10000)) dut_b (
    .clk50(clk50), .sys_init_ctrl(sys_init_ctrl), .bus(bus_b.slave));

  assign bus_b.rot_clk  = bus_a.rot_clk;
  assign bus_b.rot_en   = bus_a.rot_en;
  assign bus_b.rot_dir  = bus_a.rot_dir;
  assign bus_b.clear    = bus_a.clear;
  assign bus_b.load     = bus_a.load;
  assign bus_b.load_val = bus_a.load_val;

  logic [15:0] bcd_o [2];
  logic        wrap_o[2];
  logic        err_o [2];
  assign bcd_o[0] = bus_a.bcdint;  assign wrap_o[0] = bus_a.wrap;  assign err_o[0] = bus_a.load_err;
  assign bcd_o[1] = bus_b.bcdint;  assign wrap_o[1] = bus_b.wrap;  assign err_o[1] = bus_b.load_err;

  // clock / reset
  always #10 clk50 = ~clk50;

  // reference model and scoreboard
  int          checks = 0;
  int          errors = 0;
  int          mods[2] = '{360, 10000};
  int          mv[2];
  bit          ew[2];
  bit          ee[2];
  int          wrap_seen_a;
  int          wrap_exp_a;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_cycle(input bit fall, en, dir, clr, ld, input logic [15:0] ldv);
    bit ok;
    int dec;
    for (int i = 0; i < 2; i++) begin
      ew[i] = 1'b0;
      ee[i] = 1'b0;
      if (clr) begin
        mv[i] = 0;
      end else if (ld) begin
        ok  = 1'b1;
        dec = 0;
        for (int d = 3; d >= 0; d--) begin
          if (ldv[4*d +: 4] > 4'd9) ok = 1'b0;
          dec = dec * 10 + int'(ldv[4*d +: 4]);
        end
        if (ok && dec < mods[i]) mv[i] = dec;
        else                     ee[i] = 1'b1;
      end else if (fall && en) begin
        if (dir) begin
          if (mv[i] == mods[i] - 1) begin
`ifdef BCD_ANGLE_SAT_EN
            mv[i] = mods[i] - 1;
`else
            mv[i] = 0;
`endif
            ew[i] = 1'b1;
          end else mv[i] = mv[i] + 1;
        end else begin
          if (mv[i] == 0) begin
`ifdef BCD_ANGLE_SAT_EN
            mv[i] = 0;
`else
            mv[i] = mods[i] - 1;
`endif
            ew[i] = 1'b1;
          end else mv[i] = mv[i] - 1;
        end
      end
      exp_q.push_back(to_bcd(mv[i]));
    end
    if (ew[0]) wrap_exp_a++;
  endtask

  // driver: optional rot_clk fall, with clear/load applied in the step cycle
  task automatic cycle_op(input bit fall, en, dir, clr, ld, input logic [15:0] ldv);
    logic [15:0] exp;
    if (fall) begin
      @(negedge clk50);
      bus_a.rot_clk = 1'b0; bus_a.rot_en = en; bus_a.rot_dir = dir;
      @(negedge clk50);
      @(negedge clk50);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (bcd_o[i] !== to_bcd(mv[i])) begin
          errors++;
          $display("FAIL early_update dut%0d: got %h expected %h", i, bcd_o[i], to_bcd(mv[i]));
        end
      end
    end else begin
      @(negedge clk50);
    end
    bus_a.clear = clr; bus_a.load = ld; bus_a.load_val = ldv;
    @(negedge clk50);
    bus_a.clear = 1'b0; bus_a.load = 1'b0;
    model_cycle(fall, en, dir, clr, ld, ldv);
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (bcd_o[i] !== exp) begin
        errors++;
        $display("FAIL bcdint dut%0d: got %h expected %h", i, bcd_o[i], exp);
      end
      checks++;
      if (wrap_o[i] !== ew[i] || err_o[i] !== ee[i]) begin
        errors++;
        $display("FAIL pulses dut%0d: wrap=%b load_err=%b expected %b %b", i, wrap_o[i], err_o[i], ew[i], ee[i]);
      end
    end
    if (wrap_o[0] === 1'b1) wrap_seen_a++;
    if (fall) bus_a.rot_clk = 1'b1;
    @(negedge clk50);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wrap_o[i] !== 1'b0 || err_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width dut%0d: wrap=%b load_err=%b expected 0 0", i, wrap_o[i], err_o[i]);
      end
    end
    if (fall) @(negedge clk50);
  endtask

  task automatic test_reset();
    bus_a.rot_clk = 1'b0; bus_a.rot_en = 1'b1; bus_a.rot_dir = 1'b1;
    bus_a.clear = 1'b0; bus_a.load = 1'b0; bus_a.load_val = '0;
    sys_init_ctrl = 1'b1;
    repeat (3) @(negedge clk50);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bcd_o[i] !== 16'h0000 || wrap_o[i] !== 1'b0 || err_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h/%b/%b expected 0000/0/0", i, bcd_o[i], wrap_o[i], err_o[i]);
      end
    end
    sys_init_ctrl = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk50);
      checks++;
      if (bcd_o[0] !== 16'h0000 || wrap_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cycle %0d: got %h wrap %b expected 0000 0", c, bcd_o[0], wrap_o[0]);
      end
    end
    bus_a.rot_clk = 1'b1;
    repeat (3) @(negedge clk50);
    mv = '{0, 0};
  endtask

  task automatic test_count_up();
    wrap_seen_a = 0;
    wrap_exp_a  = 0;
    for (int n = 0; n < 361; n++) cycle_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checks++;
    if (wrap_seen_a !== wrap_exp_a) begin
      errors++;
      $display("FAIL wrap_count: got %0d expected %0d", wrap_seen_a, wrap_exp_a);
    end
  endtask

  task automatic test_count_down();
    cycle_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    cycle_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100);
    cycle_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_load();
    cycle_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0360);
    cycle_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01A0);
    cycle_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0123);
    cycle_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0359);
  endtask

  task automatic test_priority();
    cycle_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0200);
    cycle_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0250);
    cycle_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic test_mod10k();
    cycle_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9998);
    cycle_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    cycle_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    cycle_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_random();
    int          op;
    logic [15:0] v;
    for (int n = 0; n < 200; n++) begin
      op = int'($urandom_range(0, 9));
      v  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : to_bcd(int'($urandom_range(0, 9999)));
      case (op)
        0:       cycle_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v);
        1, 2:    cycle_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, v);
        3:       cycle_op(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), v);
        default: cycle_op(1'b1, ($urandom_range(0, 4) != 0), 1'($urandom), 1'b0, 1'b0, v);
      endcase
    end
  endtask

  task automatic test_async_reset();
    cycle_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0123);
    @(posedge clk50);
    #3 sys_init_ctrl = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bcd_o[i] !== 16'h0000 || wrap_o[i] !== 1'b0 || err_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset dut%0d: got %h/%b/%b expected 0000/0/0", i, bcd_o[i], wrap_o[i], err_o[i]);
      end
    end
    @(negedge clk50);
    sys_init_ctrl = 1'b0;
    mv = '{0, 0};
    repeat (3) @(negedge clk50);
    cycle_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_priority();
    test_mod10k();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
